// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline register and its forwarding front end.
// Optional build macro used by this slice: ID_EX_PERF_CNT_EN (adds the load-use bubble counter).
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ALU_OR  = 2'b00,
    ALU_ADD = 2'b01,
    ALU_MUL = 2'b10,
    ALU_SLE = 2'b11
  } alu_op_e;

  // Control half of the ID/EX register; a bubble is this struct all zero.
  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
  } idex_ctrl_t;

  localparam idex_ctrl_t BUBBLE_CTRL = '{
    valid:     1'b0,
    alu_src:   1'b0,
    alu_op:    ALU_OR,
    mem_read:  1'b0,
    mem_write: 1'b0,
    reg_write: 1'b0
  };

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus bundle between ID, the ID/EX stage, the forwarding sources and EX.
// The stage is the slave; whatever drives ID/forwarding and consumes EX is the master.
// Optional build macro for the stage: ID_EX_PERF_CNT_EN (counter is a plain port, not in this bundle).
interface id_ex_stage_if #(
  parameter int DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int REG_AW = id_ex_stage_pkg::REG_AW
);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_alu_src;
  logic [1:0]        id_alu_op;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_reg_write;

  logic              flush;
  logic              ex_hold;

  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_result;

  logic              stall_id;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_op2;
  logic [1:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_reg_write;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alu_src, id_alu_op, id_mem_read, id_mem_write, id_reg_write,
           flush, ex_hold,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  stall_id, ex_valid, ex_op1, ex_op2, ex_alu_op, ex_store_data,
           ex_rd, ex_mem_read, ex_mem_write, ex_reg_write
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alu_src, id_alu_op, id_mem_read, id_mem_write, id_reg_write,
           flush, ex_hold,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output stall_id, ex_valid, ex_op1, ex_op2, ex_alu_op, ex_store_data,
           ex_rd, ex_mem_read, ex_mem_write, ex_reg_write
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding mux: picks the youngest in-flight writer of the source register,
// falling back to the value read from the register file in ID. r0 is never forwarded.
module fwd_mux #(
  parameter int DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int REG_AW = id_ex_stage_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] fwd_data
);

  import id_ex_stage_pkg::*;

  logic exmem_hit;
  logic memwb_hit;

  // EX/MEM is younger than MEM/WB, so it wins when both write the same register.
  always_comb begin
    exmem_hit = exmem_reg_write && (exmem_rd != REG_AW'(REG_ZERO)) && (exmem_rd == src);
    memwb_hit = memwb_reg_write && (memwb_rd != REG_AW'(REG_ZERO)) && (memwb_rd == src);
    fwd_data  = reg_data;
    if (exmem_hit) begin
      fwd_data = exmem_result;
    end else if (memwb_hit) begin
      fwd_data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Optional build macro: ID_EX_PERF_CNT_EN adds output bubble_cnt, counting load-use bubbles.
module id_ex_stage #(
  parameter int DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int REG_AW = id_ex_stage_pkg::REG_AW
) (
  input  logic        clk,
  input  logic        rst_n,
  id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);

  import id_ex_stage_pkg::*;

  idex_ctrl_t        ctrl_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;

  logic              load_use;
  logic              load_bubble;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // A load in EX cannot forward its data in time for an ID instruction that reads it;
  // rt only counts when it is actually consumed (ALU source or store data).
  assign load_use = ctrl_q.valid && ctrl_q.mem_read && bus.id_valid &&
                    (rd_q != REG_AW'(REG_ZERO)) &&
                    ((rd_q == bus.id_rs) ||
                     ((rd_q == bus.id_rt) && (!bus.id_alu_src || bus.id_mem_write)));

  assign load_bubble  = load_use && !bus.ex_hold && !bus.flush;
  assign bus.stall_id = (load_use || bus.ex_hold) && !bus.flush;

  // Reset, flush and load-use all leave an all-zero bubble; hold keeps the current contents.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush || load_bubble) begin
      ctrl_q    <= BUBBLE_CTRL;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else if (!bus.ex_hold) begin
      ctrl_q    <= '{
        valid:     bus.id_valid,
        alu_src:   bus.id_alu_src,
        alu_op:    bus.id_alu_op,
        mem_read:  bus.id_mem_read,
        mem_write: bus.id_mem_write,
        reg_write: bus.id_reg_write
      };
      rs_q      <= bus.id_rs;
      rt_q      <= bus.id_rt;
      rd_q      <= bus.id_rd;
      rs_data_q <= bus.id_rs_data;
      rt_data_q <= bus.id_rt_data;
      imm_q     <= bus.id_imm;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src             (rs_q),
    .reg_data        (rs_data_q),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd        (bus.exmem_rd),
    .exmem_result    (bus.exmem_result),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_rd        (bus.memwb_rd),
    .memwb_result    (bus.memwb_result),
    .fwd_data        (fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src             (rt_q),
    .reg_data        (rt_data_q),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd        (bus.exmem_rd),
    .exmem_result    (bus.exmem_result),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_rd        (bus.memwb_rd),
    .memwb_result    (bus.memwb_result),
    .fwd_data        (fwd_rt)
  );

  assign bus.ex_valid      = ctrl_q.valid;
  assign bus.ex_op1        = fwd_rs;
  assign bus.ex_op2        = ctrl_q.alu_src ? imm_q : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.ex_alu_op     = ctrl_q.alu_op;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_reg_write  = ctrl_q.reg_write;

`ifdef ID_EX_PERF_CNT_EN
  // Counts only bubbles caused by load-use; flush and hold are not interesting here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (load_bubble) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized run
// against an instruction-level reference model. Honours ID_EX_PERF_CNT_EN.
module tb_id_ex_stage;

  import id_ex_stage_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  // Instruction as it sits in EX, in reference-model terms.
  typedef struct {
    bit          valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    bit          alu_src;
    logic [1:0]  alu_op;
    bit          mem_read, mem_write, reg_write;
  } instr_t;

  instr_t      m = '{default: 0};
  logic [31:0] m_cnt = '0;
  int          checks = 0;
  int          failures = 0;

  // Value an EX operand should see: the youngest pending writer of that register, else the stored value.
  function automatic logic [31:0] m_fwd(logic [4:0] src, logic [31:0] stored);
    bit          w_en [2];
    logic [4:0]  w_rd [2];
    logic [31:0] w_val [2];
    w_en[0] = bus.exmem_reg_write; w_rd[0] = bus.exmem_rd; w_val[0] = bus.exmem_result;
    w_en[1] = bus.memwb_reg_write; w_rd[1] = bus.memwb_rd; w_val[1] = bus.memwb_result;
    for (int i = 0; i < 2; i++) begin
      if (w_en[i] && w_rd[i] != 5'd0 && w_rd[i] == src) return w_val[i];
    end
    return stored;
  endfunction

  // The ID instruction needs a register that the load currently in EX has not fetched yet.
  function automatic bit m_hazard();
    if (!(m.valid && m.mem_read && bus.id_valid) || m.rd == 5'd0) return 1'b0;
    if (bus.id_rs == m.rd) return 1'b1;
    return (bus.id_rt == m.rd) && (!bus.id_alu_src || bus.id_mem_write);
  endfunction

  function automatic bit m_stall();
    return (m_hazard() || bus.ex_hold) && !bus.flush;
  endfunction

  // Advance one clock and move the reference model the same way.
  task automatic tick();
    instr_t nxt;
    bit     bubble_in;
    bubble_in = m_hazard() && !bus.ex_hold && !bus.flush;
    if (!rst_n || bus.flush || bubble_in) begin
      nxt = '{default: 0};
    end else if (bus.ex_hold) begin
      nxt = m;
    end else begin
      nxt = '{valid: bus.id_valid, rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
              rs_data: bus.id_rs_data, rt_data: bus.id_rt_data, imm: bus.id_imm,
              alu_src: bus.id_alu_src, alu_op: bus.id_alu_op, mem_read: bus.id_mem_read,
              mem_write: bus.id_mem_write, reg_write: bus.id_reg_write};
    end
    @(posedge clk);
    #1;
    if (!rst_n) m_cnt = '0;
    else if (bubble_in) m_cnt = m_cnt + 32'd1;
    m = nxt;
  endtask

  task automatic set_id(input bit v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                        input bit src, input logic [1:0] op, input bit mr, input bit mw, input bit rw);
    bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
    bus.id_alu_src = src; bus.id_alu_op = op;
    bus.id_mem_read = mr; bus.id_mem_write = mw; bus.id_reg_write = rw;
  endtask

  task automatic clear_fwd();
    bus.exmem_reg_write = 1'b0; bus.exmem_rd = '0; bus.exmem_result = '0;
    bus.memwb_reg_write = 1'b0; bus.memwb_rd = '0; bus.memwb_result = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.ex_hold = 1'b0;
    clear_fwd();
    set_id(1, 5'd1, 5'd2, 5'd3, 32'h1111, 32'h2222, 32'h3333, 0, ALU_ADD, 1, 0, 1);
    tick();
    tick();
    #1;
    checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", bus.ex_valid); end
    checks++; if (bus.ex_reg_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_reg_write got=%b want=0", bus.ex_reg_write); end
    checks++; if (bus.ex_op1 !== 32'h0) begin failures++; $display("[TB] FAIL reset_op1 got=%h want=0", bus.ex_op1); end
    checks++; if (bus.ex_op2 !== 32'h0) begin failures++; $display("[TB] FAIL reset_op2 got=%h want=0", bus.ex_op2); end
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b want=0", bus.stall_id); end
    checks++; if (bus.ex_alu_op !== 2'b00) begin failures++; $display("[TB] FAIL reset_alu_op got=%b want=00", bus.ex_alu_op); end
`ifdef ID_EX_PERF_CNT_EN
    checks++; if (bubble_cnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d want=0", bubble_cnt); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    clear_fwd();
    set_id(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 0, ALU_ADD, 0, 0, 1);
    tick();
    #1;
    checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("[TB] FAIL capture_valid got=%b want=1", bus.ex_valid); end
    checks++; if (bus.ex_op1 !== 32'd5) begin failures++; $display("[TB] FAIL capture_op1 got=%h want=5", bus.ex_op1); end
    checks++; if (bus.ex_op2 !== 32'd7) begin failures++; $display("[TB] FAIL capture_op2 got=%h want=7", bus.ex_op2); end
    checks++; if (bus.ex_alu_op !== 2'b01) begin failures++; $display("[TB] FAIL capture_alu_op got=%b want=01", bus.ex_alu_op); end
    checks++; if (bus.ex_rd !== 5'd3) begin failures++; $display("[TB] FAIL capture_rd got=%0d want=3", bus.ex_rd); end
  endtask

  task automatic test_forward();
    clear_fwd();
    set_id(1, 5'd3, 5'd6, 5'd8, 32'h11, 32'h22, 32'd0, 0, ALU_ADD, 0, 0, 1);
    tick();
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'hAA;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'hBB;
    #1;
    checks++; if (bus.ex_op1 !== 32'hAA) begin failures++; $display("[TB] FAIL fwd_exmem got=%h want=aa", bus.ex_op1); end
    checks++; if (bus.ex_op2 !== 32'h22) begin failures++; $display("[TB] FAIL fwd_rt_untouched got=%h want=22", bus.ex_op2); end
    bus.exmem_reg_write = 1'b0;
    #1;
    checks++; if (bus.ex_op1 !== 32'hBB) begin failures++; $display("[TB] FAIL fwd_memwb got=%h want=bb", bus.ex_op1); end
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0;
    bus.memwb_rd = 5'd0;
    set_id(1, 5'd0, 5'd0, 5'd9, 32'h55, 32'h66, 32'd0, 0, ALU_OR, 0, 0, 1);
    tick();
    #1;
    checks++; if (bus.ex_op1 !== 32'h55) begin failures++; $display("[TB] FAIL fwd_r0_op1 got=%h want=55", bus.ex_op1); end
    checks++; if (bus.ex_op2 !== 32'h66) begin failures++; $display("[TB] FAIL fwd_r0_op2 got=%h want=66", bus.ex_op2); end
  endtask

  task automatic test_load_use();
    clear_fwd();
    set_id(1, 5'd1, 5'd2, 5'd4, 32'd0, 32'd0, 32'h10, 1, ALU_ADD, 1, 0, 1);
    tick();
    set_id(1, 5'd4, 5'd5, 5'd6, 32'hDEAD, 32'h77, 32'd0, 0, ALU_ADD, 0, 0, 1);
    #1;
    checks++; if (bus.stall_id !== 1'b1) begin failures++; $display("[TB] FAIL lu_stall got=%b want=1", bus.stall_id); end
    tick();
    #1;
    checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("[TB] FAIL lu_bubble got=%b want=0", bus.ex_valid); end
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("[TB] FAIL lu_stall_drop got=%b want=0", bus.stall_id); end
`ifdef ID_EX_PERF_CNT_EN
    checks++; if (bubble_cnt !== 32'd1) begin failures++; $display("[TB] FAIL lu_cnt got=%0d want=1", bubble_cnt); end
`endif
    tick();
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd4; bus.memwb_result = 32'h1234;
    #1;
    checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("[TB] FAIL lu_enter_valid got=%b want=1", bus.ex_valid); end
    checks++; if (bus.ex_op1 !== 32'h1234) begin failures++; $display("[TB] FAIL lu_enter_op1 got=%h want=1234", bus.ex_op1); end
    checks++; if (bus.ex_op2 !== 32'h77) begin failures++; $display("[TB] FAIL lu_enter_op2 got=%h want=77", bus.ex_op2); end
  endtask

  task automatic test_immediate();
    clear_fwd();
    set_id(1, 5'd1, 5'd7, 5'd2, 32'd3, 32'd1, 32'hFFFF_FFF0, 1, ALU_ADD, 0, 1, 0);
    tick();
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd7; bus.exmem_result = 32'd9;
    #1;
    checks++; if (bus.ex_op2 !== 32'hFFFF_FFF0) begin failures++; $display("[TB] FAIL imm_op2 got=%h want=fffffff0", bus.ex_op2); end
    checks++; if (bus.ex_store_data !== 32'd9) begin failures++; $display("[TB] FAIL imm_store got=%h want=9", bus.ex_store_data); end
    checks++; if (bus.ex_mem_write !== 1'b1) begin failures++; $display("[TB] FAIL imm_mem_write got=%b want=1", bus.ex_mem_write); end
  endtask

  task automatic test_hold_flush();
    clear_fwd();
    set_id(1, 5'd10, 5'd11, 5'd12, 32'h100, 32'h200, 32'd0, 0, ALU_SLE, 0, 0, 1);
    tick();
    bus.ex_hold = 1'b1;
    set_id(1, 5'd13, 5'd14, 5'd15, 32'h300, 32'h400, 32'd0, 0, ALU_OR, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.stall_id !== 1'b1) begin failures++; $display("[TB] FAIL hold_stall[%0d] got=%b want=1", i, bus.stall_id); end
      checks++; if (bus.ex_op1 !== 32'h100) begin failures++; $display("[TB] FAIL hold_op1[%0d] got=%h want=100", i, bus.ex_op1); end
      checks++; if (bus.ex_alu_op !== 2'b11) begin failures++; $display("[TB] FAIL hold_alu_op[%0d] got=%b want=11", i, bus.ex_alu_op); end
      tick();
    end
    #1;
    checks++; if (bus.ex_op2 !== 32'h200) begin failures++; $display("[TB] FAIL hold_op2 got=%h want=200", bus.ex_op2); end
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.stall_id !== 1'b0) begin failures++; $display("[TB] FAIL flush_stall got=%b want=0", bus.stall_id); end
    tick();
    #1;
    checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got=%b want=0", bus.ex_valid); end
    checks++; if (bus.ex_reg_write !== 1'b0) begin failures++; $display("[TB] FAIL flush_reg_write got=%b want=0", bus.ex_reg_write); end
    bus.flush = 1'b0;
    bus.ex_hold = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e_op1, e_op2, e_st;
    for (int c = 0; c < 400; c++) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      bus.flush   = ($urandom_range(0, 9) == 0);
      bus.ex_hold = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
             1'($urandom_range(0, 1)));
      bus.exmem_reg_write = 1'($urandom_range(0, 1)); bus.exmem_rd = 5'($urandom_range(0, 3));
      bus.exmem_result    = $urandom;
      bus.memwb_reg_write = 1'($urandom_range(0, 1)); bus.memwb_rd = 5'($urandom_range(0, 3));
      bus.memwb_result    = $urandom;
      #1;
      e_op1 = m_fwd(m.rs, m.rs_data);
      e_st  = m_fwd(m.rt, m.rt_data);
      e_op2 = m.alu_src ? m.imm : e_st;
      checks++; if (bus.stall_id !== m_stall()) begin failures++; $display("[TB] FAIL rnd_stall[%0d] got=%b want=%b", c, bus.stall_id, m_stall()); end
      checks++; if (bus.ex_valid !== m.valid) begin failures++; $display("[TB] FAIL rnd_valid[%0d] got=%b want=%b", c, bus.ex_valid, m.valid); end
      checks++; if (bus.ex_op1 !== e_op1) begin failures++; $display("[TB] FAIL rnd_op1[%0d] got=%h want=%h", c, bus.ex_op1, e_op1); end
      checks++; if (bus.ex_op2 !== e_op2) begin failures++; $display("[TB] FAIL rnd_op2[%0d] got=%h want=%h", c, bus.ex_op2, e_op2); end
      checks++; if (bus.ex_store_data !== e_st) begin failures++; $display("[TB] FAIL rnd_store[%0d] got=%h want=%h", c, bus.ex_store_data, e_st); end
      checks++; if (bus.ex_alu_op !== m.alu_op) begin failures++; $display("[TB] FAIL rnd_alu_op[%0d] got=%b want=%b", c, bus.ex_alu_op, m.alu_op); end
      checks++; if (bus.ex_rd !== m.rd) begin failures++; $display("[TB] FAIL rnd_rd[%0d] got=%0d want=%0d", c, bus.ex_rd, m.rd); end
      checks++;
      if ({bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write} !== {m.mem_read, m.mem_write, m.reg_write}) begin
        failures++;
        $display("[TB] FAIL rnd_ctrl[%0d] got=%b%b%b want=%b%b%b", c, bus.ex_mem_read, bus.ex_mem_write,
                 bus.ex_reg_write, m.mem_read, m.mem_write, m.reg_write);
      end
`ifdef ID_EX_PERF_CNT_EN
      checks++; if (bubble_cnt !== m_cnt) begin failures++; $display("[TB] FAIL rnd_cnt[%0d] got=%0d want=%0d", c, bubble_cnt, m_cnt); end
`endif
      tick();
    end
    rst_n = 1'b1;
    bus.flush = 1'b0;
    bus.ex_hold = 1'b0;
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.ex_hold = 1'b0;
    clear_fwd();
    set_id(0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, ALU_OR, 0, 0, 0);
    $display("[TB] starting id_ex_stage bench");
    test_reset();
    test_capture();
    test_forward();
    test_load_use();
    test_immediate();
    test_hold_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
